wb_stage: RTL

- Final (write-back) stage of the 5-stage pipeline CPU; receives the MEM-stage outputs (wreg, m2reg, memory read data, ALU result, destination register, instruction tag).
- Holds them in a MEM/WB pipeline register and selects the write-back value.
- Drives the register-file write port, the forwarding source for EX, and an instruction-retire counter for the debug display.

---
 rtl/wb_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back mux, register-file port and retire counter.
// Optional trace output guarded by WB_TRACE_EN (trace_strobe / trace_word).
module wb_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_valid,
    input  logic            mem_wreg,
    input  logic            mem_m2reg,
    input  logic [DW-1:0]   mem_mdata,
    input  logic [DW-1:0]   mem_aluR,
    input  logic [RW-1:0]   mem_destR,
    input  logic [3:0]      MEM_ins_type,
    input  logic [3:0]      MEM_ins_number,
    output logic            wb_we,
    output logic [RW-1:0]   wb_destR,
    output logic [DW-1:0]   wb_data,
    output logic [3:0]      WB_ins_type,
    output logic [3:0]      WB_ins_number,
    output logic            wb_valid,
    output logic [CNTW-1:0] retire_cnt
`ifdef WB_TRACE_EN
    ,
    output logic               trace_strobe,
    output logic [DW+RW+7:0]   trace_word
`endif
);

    logic            valid_q, valid_d;
    logic            wreg_q, wreg_d;
    logic            m2reg_q, m2reg_d;
    logic [DW-1:0]   mdata_q, mdata_d;
    logic [DW-1:0]   aluR_q, aluR_d;
    logic [RW-1:0]   destR_q, destR_d;
    logic [3:0]      type_q, type_d;
    logic [3:0]      num_q, num_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            retire;

    // The WB instruction leaves the slot whenever the register is not held;
    // a flush overrides stall, so it also retires the current occupant.
    assign retire = valid_q & (flush | ~stall);

    always_comb begin
        valid_d = valid_q;
        wreg_d  = wreg_q;
        m2reg_d = m2reg_q;
        mdata_d = mdata_q;
        aluR_d  = aluR_q;
        destR_d = destR_q;
        type_d  = type_q;
        num_d   = num_q;
        cnt_d   = retire ? cnt_q + CNTW'(1) : cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            wreg_d  = 1'b0;
            type_d  = 4'd0;
            num_d   = 4'd0;
        end else if (!stall) begin
            valid_d = mem_valid;
            wreg_d  = mem_wreg;
            m2reg_d = mem_m2reg;
            mdata_d = mem_mdata;
            aluR_d  = mem_aluR;
            destR_d = mem_destR;
            type_d  = MEM_ins_type;
            num_d   = MEM_ins_number;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            mdata_q <= '0;
            aluR_q  <= '0;
            destR_q <= '0;
            type_q  <= 4'd0;
            num_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            mdata_q <= mdata_d;
            aluR_q  <= aluR_d;
            destR_q <= destR_d;
            type_q  <= type_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_data       = m2reg_q ? mdata_q : aluR_q;
    assign wb_we         = valid_q & wreg_q & (destR_q != '0);
    assign wb_destR      = destR_q;
    assign wb_valid      = valid_q;
    assign WB_ins_type   = type_q;
    assign WB_ins_number = num_q;
    assign retire_cnt    = cnt_q;

`ifdef WB_TRACE_EN
    logic               trace_strobe_q;
    logic [DW+RW+7:0]   trace_word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_strobe_q <= 1'b0;
            trace_word_q   <= '0;
        end else begin
            trace_strobe_q <= retire & wb_we;
            if (retire & wb_we) begin
                trace_word_q <= {type_q, num_q, destR_q, wb_data};
            end
        end
    end

    assign trace_strobe = trace_strobe_q;
    assign trace_word   = trace_word_q;
`endif

endmodule
